// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the two-client cache port arbiter.
package cache_arb_pkg;

    localparam int REQ_WIDTH       = 70;
    localparam int RESP_WIDTH      = 52;
    localparam int IGNORE_RESP_BIT = 0;

    typedef enum logic {
        ARB_RR  = 1'b0,
        ARB_TDM = 1'b1
    } arb_mode_t;

    typedef logic client_id_t;

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selection: TDM slot masking, then round-robin tie-break.
module arb_grant
    import cache_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  client_id_t rr_ptr,
    input  arb_mode_t  mode,
    input  client_id_t slot_owner,
    output logic [1:0] gnt
);

    logic [1:0] masked;

    always_comb begin
        masked = elig;
        if (mode == ARB_TDM)
            masked = elig & (slot_owner ? 2'b10 : 2'b01);
        gnt = masked;
        // Only a real tie consults the priority pointer.
        if (&masked)
            gnt = rr_ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one single-cycle cache put/get port between two clients; responses
// are routed back to the client that issued the outstanding request.
module cache_arbiter #(
    parameter int REQ_WIDTH   = cache_arb_pkg::REQ_WIDTH,
    parameter int RESP_WIDTH  = cache_arb_pkg::RESP_WIDTH,
    parameter int MODE        = 0,
    parameter int SLOT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req0_put_valid,
    output logic                  req0_put_ready,
    input  logic [REQ_WIDTH-1:0]  req0_put_request,
    input  logic                  req0_get_valid,
    output logic                  req0_get_ready,
    output logic [RESP_WIDTH-1:0] req0_get_response,
    input  logic                  req1_put_valid,
    output logic                  req1_put_ready,
    input  logic [REQ_WIDTH-1:0]  req1_put_request,
    input  logic                  req1_get_valid,
    output logic                  req1_get_ready,
    output logic [RESP_WIDTH-1:0] req1_get_response,
    output logic                  cache_put_valid,
    input  logic                  cache_put_ready,
    output logic [REQ_WIDTH-1:0]  cache_put_request,
    output logic                  cache_get_valid,
    input  logic                  cache_get_ready,
    input  logic [RESP_WIDTH-1:0] cache_get_response
);

    import cache_arb_pkg::*;

    localparam arb_mode_t ARB_MODE = (MODE == 1) ? ARB_TDM : ARB_RR;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

    logic          owner_valid;
    client_id_t    owner_id;
    client_id_t    rr_ptr;
    logic [CW-1:0] slot_cnt;
    client_id_t    slot_owner;

    logic [1:0] put_valid, get_valid, elig, gnt;
    logic       drain, free, put_fire;
    client_id_t gnt_id;

    assign put_valid = {req1_put_valid, req1_put_valid ? 1'b0 : 1'b0} | {1'b0, req0_put_valid};
    assign get_valid = {req1_get_valid, req0_get_valid};

    // A response drains in the same cycle a new request may issue.
    assign cache_get_valid = RST_N && owner_valid && get_valid[owner_id];
    assign drain           = cache_get_valid && cache_get_ready;
    assign free            = !owner_valid || drain;
    assign elig            = put_valid & {2{free && RST_N}};

    arb_grant u_grant (
        .elig       (elig),
        .rr_ptr     (rr_ptr),
        .mode       (ARB_MODE),
        .slot_owner (slot_owner),
        .gnt        (gnt)
    );

    assign gnt_id            = gnt[1];
    assign cache_put_valid   = |gnt;
    assign cache_put_request = gnt[1] ? req1_put_request : req0_put_request;
    assign req0_put_ready    = gnt[0] && cache_put_ready;
    assign req1_put_ready    = gnt[1] && cache_put_ready;
    assign put_fire          = cache_put_valid && cache_put_ready;

    assign req0_get_ready    = RST_N && owner_valid && (owner_id == 1'b0) && cache_get_ready;
    assign req1_get_ready    = RST_N && owner_valid && (owner_id == 1'b1) && cache_get_ready;
    assign req0_get_response = cache_get_response;
    assign req1_get_response = cache_get_response;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner_valid <= 1'b0;
            owner_id    <= 1'b0;
            rr_ptr      <= 1'b0;
        end else if (put_fire) begin
            rr_ptr      <= ~gnt_id;
            owner_valid <= ~cache_put_request[IGNORE_RESP_BIT];
            owner_id    <= gnt_id;
        end else if (drain) begin
            owner_valid <= 1'b0;
        end
    end

    // Slot timing is free-running and independent of traffic.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_cnt   <= '0;
            slot_owner <= 1'b0;
        end else if (ARB_MODE == ARB_TDM) begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt   <= '0;
                slot_owner <= ~slot_owner;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule
